// File: rtl/map_scroll_controller.sv
// rtl/map_scroll_controller.sv - tile-grid walk engine with collision lookup, walk and bump
module map_scroll_controller #(
  parameter int TILE_PX     = 16,
  parameter int STEP_PX     = 2,
  parameter int MAP_W       = 32,
  parameter int MAP_H       = 32,
  parameter int START_X     = 8,
  parameter int START_Y     = 8,
  parameter int BUMP_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       Character_Moving,
  input  logic [1:0] Direction,
  output logic [9:0] coll_addr,
  input  logic       coll_data,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [1:0] Facing,
  output logic [1:0] walk_phase,
  output logic       Busy
);

  localparam int TXW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int TYW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int SW  = $clog2(TILE_PX + 1);
  localparam int BW  = $clog2(BUMP_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_WALK,
    S_BUMP
  } state_t;

  state_t         state, state_n;
  logic [TXW-1:0] tile_x, tile_x_n, tgt_x, tgt_x_n;
  logic [TYW-1:0] tile_y, tile_y_n, tgt_y, tgt_y_n;
  logic [SW-1:0]  sub, sub_n;
  logic [BW-1:0]  bump_cnt, bump_cnt_n;
  logic [1:0]     facing_q, facing_n;
  logic           foot, foot_n;
  logic           half, half_n;
  logic [9:0]     pos_x, pos_x_n, pos_y, pos_y_n;
  logic [9:0]     addr_q, addr_n;
  logic           fc_q, fc_d;
  logic           tick;

  // Scratch for target computation in IDLE
  logic [TXW-1:0] tx;
  logic [TYW-1:0] ty;
  logic           off_map;
  logic [9:0]     base_x, base_y;

  assign tick       = fc_q & ~fc_d;
  assign Busy       = (state != S_IDLE);
  assign Facing     = facing_q;
  assign coll_addr  = addr_q;
  assign PosX       = pos_x;
  assign PosY       = pos_y;
  assign walk_phase = {foot, half};

  // Frame-edge detector: register VGA_VS once, pulse on its rising edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_q <= 1'b0;
      fc_d <= 1'b0;
    end else begin
      fc_q <= frame_clk;
      fc_d <= fc_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      tile_x   <= TXW'(START_X);
      tile_y   <= TYW'(START_Y);
      tgt_x    <= TXW'(START_X);
      tgt_y    <= TYW'(START_Y);
      sub      <= '0;
      bump_cnt <= '0;
      facing_q <= 2'd1;
      foot     <= 1'b0;
      half     <= 1'b0;
      pos_x    <= 10'(START_X * TILE_PX);
      pos_y    <= 10'(START_Y * TILE_PX);
      addr_q   <= '0;
    end else begin
      state    <= state_n;
      tile_x   <= tile_x_n;
      tile_y   <= tile_y_n;
      tgt_x    <= tgt_x_n;
      tgt_y    <= tgt_y_n;
      sub      <= sub_n;
      bump_cnt <= bump_cnt_n;
      facing_q <= facing_n;
      foot     <= foot_n;
      half     <= half_n;
      pos_x    <= pos_x_n;
      pos_y    <= pos_y_n;
      addr_q   <= addr_n;
    end
  end

  // Next-state logic: request decode, collision wait, walk stepping and bump timing
  always_comb begin
    state_n    = state;
    tile_x_n   = tile_x;
    tile_y_n   = tile_y;
    tgt_x_n    = tgt_x;
    tgt_y_n    = tgt_y;
    sub_n      = sub;
    bump_cnt_n = bump_cnt;
    facing_n   = facing_q;
    foot_n     = foot;
    addr_n     = addr_q;
    tx         = tile_x;
    ty         = tile_y;
    off_map    = 1'b0;

    case (state)
      S_IDLE: begin
        if (tick && Character_Moving) begin
          facing_n = Direction;
          // Edge test happens before any decrement so tile coordinates never wrap
          case (Direction)
            2'd0: if (tile_y == '0) off_map = 1'b1; else ty = tile_y - 1'b1;
            2'd1: if (tile_y == TYW'(MAP_H - 1)) off_map = 1'b1; else ty = tile_y + 1'b1;
            2'd2: if (tile_x == '0) off_map = 1'b1; else tx = tile_x - 1'b1;
            default: if (tile_x == TXW'(MAP_W - 1)) off_map = 1'b1; else tx = tile_x + 1'b1;
          endcase
          tgt_x_n = tx;
          tgt_y_n = ty;
          if (off_map) begin
            // No ROM read for a target outside the map
            bump_cnt_n = '0;
            state_n    = S_BUMP;
          end else begin
            addr_n  = 10'(ty) * 10'(MAP_W) + 10'(tx);
            state_n = S_CHECK;
          end
        end
      end

      S_CHECK: state_n = S_WAIT;

      S_WAIT: begin
        if (coll_data) begin
          bump_cnt_n = '0;
          state_n    = S_BUMP;
        end else begin
          sub_n   = '0;
          state_n = S_WALK;
        end
      end

      S_WALK: begin
        if (tick) begin
          if (sub + SW'(STEP_PX) >= SW'(TILE_PX)) begin
            tile_x_n = tgt_x;
            tile_y_n = tgt_y;
            sub_n    = '0;
            foot_n   = ~foot;
            state_n  = S_IDLE;
          end else begin
            sub_n = sub + SW'(STEP_PX);
          end
        end
      end

      S_BUMP: begin
        if (tick) begin
          if (bump_cnt == BW'(BUMP_FRAMES - 1)) begin
            bump_cnt_n = '0;
            state_n    = S_IDLE;
          end else begin
            bump_cnt_n = bump_cnt + 1'b1;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Pixel position and half-step flag, derived from tile plus in-flight sub offset
  always_comb begin
    base_x  = 10'(tile_x) * 10'(TILE_PX);
    base_y  = 10'(tile_y) * 10'(TILE_PX);
    pos_x_n = base_x;
    pos_y_n = base_y;
    half_n  = 1'b0;
    if (state == S_WALK) begin
      half_n = (sub >= SW'(TILE_PX / 2));
      case (facing_q)
        2'd0:    pos_y_n = base_y - 10'(sub);
        2'd1:    pos_y_n = base_y + 10'(sub);
        2'd2:    pos_x_n = base_x - 10'(sub);
        default: pos_x_n = base_x + 10'(sub);
      endcase
    end
  end

endmodule
